multicycle_controller: RTL and testbench

- Multi-cycle successor to the single-cycle control unit.
- FSM sequencing fetch/decode/execute/memory/writeback over a shared memory and ALU, with a MemReady wait-state handshake.
- Adds full branch-condition decode, bus timeout and an illegal-instruction trap.
- Sits between the instruction register and the multicycle datapath; all strobes are decoded from the state register.

---
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/multicycle_controller.sv | 261 ++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// The datapath side drives instruction/flags/handshake; the controller drives strobes and status.
`timescale 1ns/1ps
interface multicycle_controller_if;
    logic [31:0] Instr;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [2:0]  ALUControl;
    logic        Trap;
    logic [1:0]  TrapCause;
    logic [3:0]  State;

    modport master (
        output Instr, Zero, MemReady,
        input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
        input  Trap, TrapCause, State
    );

    modport slave (
        input  Instr, Zero, MemReady,
        output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl,
        output Trap, TrapCause, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM with MemReady wait states, bus timeout and illegal-instruction trap.
// Optional LUI/AUIPC support is enabled by defining MC_UTYPE_EN.
`timescale 1ns/1ps
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    multicycle_controller_if.slave  bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
`ifdef MC_UTYPE_EN
        S_UTYPE    = 4'd12,
`endif
        S_TRAP     = 4'd15
    } state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_trap;
    logic [1:0]          r_cause;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7b5;
    logic       w_timeout;
    logic       w_unused_instr;

    logic       w_pcwrite, w_adrsrc, w_memread, w_memwrite, w_irwrite, w_regwrite;
    logic [1:0] w_resultsrc, w_alusrca, w_alusrcb;
    logic [2:0] w_immsrc, w_aluctrl;

    assign w_opcode       = bus.Instr[6:0];
    assign w_funct3       = bus.Instr[14:12];
    assign w_funct7b5     = bus.Instr[30];
    assign w_unused_instr = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};
    assign w_timeout      = (MEM_TIMEOUT != 0) && (r_wait == WAIT_LAST);

    function automatic logic [2:0] f_alu_ctrl(input logic [2:0] funct3, input logic is_r,
                                              input logic funct7b5);
        case (funct3)
            3'b000:  return (is_r && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b011:  return 3'b110;
            3'b100:  return 3'b100;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] f_branch_ctrl(input logic [2:0] funct3);
        if (!funct3[2]) return 3'b001;
        return funct3[1] ? 3'b110 : 3'b101;
    endfunction

    // Wait counter only survives while a state holds, so it defaults to clear every cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_trap  <= 1'b0;
            r_cause <= 2'b00;
        end else begin
            r_wait <= '0;
            case (r_state)
                S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                    if (bus.MemReady) begin
                        case (r_state)
                            S_FETCH:   r_state <= S_DECODE;
                            S_MEMREAD: r_state <= S_MEMWB;
                            default:   r_state <= S_FETCH;
                        endcase
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= 2'b10;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    case (w_opcode)
                        OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                        OP_R, OP_I: begin
                            if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                                r_state <= S_TRAP;
                                r_trap  <= 1'b1;
                                r_cause <= 2'b01;
                            end else begin
                                r_state <= w_opcode[5] ? S_EXECR : S_EXECI;
                            end
                        end
                        OP_BRANCH: begin
                            if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
                                r_state <= S_TRAP;
                                r_trap  <= 1'b1;
                                r_cause <= 2'b01;
                            end else begin
                                r_state <= S_BRANCH;
                            end
                        end
                        OP_JAL:  r_state <= S_JAL;
                        OP_JALR: r_state <= S_JALR;
`ifdef MC_UTYPE_EN
                        OP_LUI, OP_AUIPC: r_state <= S_UTYPE;
`endif
                        default: begin
                            r_state <= S_TRAP;
                            r_trap  <= 1'b1;
                            r_cause <= 2'b01;
                        end
                    endcase
                end
                S_MEMADR: r_state <= w_opcode[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMWB:  r_state <= S_FETCH;
                S_EXECR:  r_state <= S_ALUWB;
                S_EXECI:  r_state <= S_ALUWB;
                S_ALUWB:  r_state <= S_FETCH;
                S_BRANCH: r_state <= S_FETCH;
                S_JALR:   r_state <= S_JAL;
                S_JAL:    r_state <= S_ALUWB;
`ifdef MC_UTYPE_EN
                S_UTYPE:  r_state <= S_ALUWB;
`endif
                default:  r_state <= S_TRAP;
            endcase
        end
    end

    // Strobes decode from the state register, gated by RST so an access drops immediately.
    always_comb begin
        w_pcwrite   = 1'b0;
        w_adrsrc    = 1'b0;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_immsrc    = 3'b000;
        w_aluctrl   = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_memread   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_irwrite   = bus.MemReady;
                w_pcwrite   = bus.MemReady;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                w_immsrc  = 3'b010;
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_immsrc  = (w_opcode == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                w_adrsrc  = 1'b1;
                w_memread = 1'b1;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECR: begin
                w_alusrca = 2'b10;
                w_aluctrl = f_alu_ctrl(w_funct3, 1'b1, w_funct7b5);
            end
            S_EXECI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluctrl = f_alu_ctrl(w_funct3, 1'b0, w_funct7b5);
            end
            S_ALUWB:  w_regwrite = 1'b1;
            S_BRANCH: begin
                w_alusrca = 2'b10;
                w_aluctrl = f_branch_ctrl(w_funct3);
                w_pcwrite = bus.Zero ^ w_funct3[0] ^ w_funct3[2];
            end
            S_JALR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
            end
            S_JAL: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b10;
                w_pcwrite = 1'b1;
            end
`ifdef MC_UTYPE_EN
            S_UTYPE: begin
                w_alusrca = (w_opcode == OP_LUI) ? 2'b11 : 2'b01;
                w_alusrcb = 2'b01;
                w_immsrc  = 3'b100;
            end
`endif
            default: ;
        endcase
        if (RST) begin
            w_pcwrite   = 1'b0;
            w_adrsrc    = 1'b0;
            w_memread   = 1'b0;
            w_memwrite  = 1'b0;
            w_irwrite   = 1'b0;
            w_regwrite  = 1'b0;
            w_resultsrc = 2'b00;
            w_alusrca   = 2'b00;
            w_alusrcb   = 2'b00;
            w_immsrc    = 3'b000;
            w_aluctrl   = 3'b000;
        end
    end

    assign bus.PCWrite    = w_pcwrite;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.MemRead    = w_memread;
    assign bus.MemWrite   = w_memwrite;
    assign bus.IRWrite    = w_irwrite;
    assign bus.RegWrite   = w_regwrite;
    assign bus.ResultSrc  = w_resultsrc;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.ImmSrc     = w_immsrc;
    assign bus.ALUControl = w_aluctrl;
    assign bus.Trap       = r_trap;
    assign bus.TrapCause  = r_cause;
    assign bus.State      = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control words queued and checked.
`timescale 1ns/1ps
module tb_multicycle_controller;
    logic CLK = 1'b0;
    logic RST;
    int   n_asserts = 0;
    int   n_fail    = 0;

    multicycle_controller_if bus();

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [24:0] e;
        logic        rdy;
        logic        z;
    } step_t;

    step_t q[$];
    string tq[$];

    // {State, Trap, TrapCause, PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
    //  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}
    function automatic logic [24:0] V(input logic [3:0] st, input logic [5:0] strb,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [2:0] imm,
                                      input logic [2:0] alu, input logic t, input logic [1:0] c);
        return {st, t, c, strb, rs, sa, sb, imm, alu};
    endfunction

    function automatic logic [24:0] obs();
        return {bus.State, bus.Trap, bus.TrapCause, bus.PCWrite, bus.AdrSrc, bus.MemRead,
                bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc, bus.ALUSrcA,
                bus.ALUSrcB, bus.ImmSrc, bus.ALUControl};
    endfunction

    task automatic check(input string tag, input logic [24:0] o, input logic [24:0] e);
        n_asserts++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input string tag, input logic [24:0] e, input logic rdy, input logic z);
        step_t s;
        s.e = e; s.rdy = rdy; s.z = z;
        q.push_back(s);
        tq.push_back(tag);
    endtask

    task automatic drain();
        step_t s;
        string t;
        while (q.size() > 0) begin
            s = q.pop_front();
            t = tq.pop_front();
            bus.MemReady = s.rdy;
            bus.Zero     = s.z;
            @(negedge CLK);
            check(t, obs(), s.e);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        logic [24:0] o;
        RST = 1'b1;
        @(negedge CLK);
        o = obs();
        check({tag, " strobes"}, {7'd0, o[17:0]}, 25'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        o = obs();
        check({tag, " state"}, {o[24:18], 18'd0}, 25'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] fw, fr, dec, exi_add, exr_sub, awb, madr_l, madr_s, mrd, mwb, mwr;
        logic [24:0] br_t, br_nt, bltu, jalr, jal, trap01, trap10;
`ifdef MC_UTYPE_EN
        logic [24:0] utype;
        utype   = V(4'd12, 6'b000000, 2'b00, 2'b11, 2'b01, 3'b100, 3'b000, 1'b0, 2'b00);
`endif
        fw      = V(4'd0,  6'b001000, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 2'b00);
        fr      = V(4'd0,  6'b101010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 1'b0, 2'b00);
        dec     = V(4'd1,  6'b000000, 2'b00, 2'b01, 2'b01, 3'b010, 3'b000, 1'b0, 2'b00);
        exi_add = V(4'd7,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 2'b00);
        exr_sub = V(4'd6,  6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 1'b0, 2'b00);
        awb     = V(4'd8,  6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 2'b00);
        madr_l  = V(4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 2'b00);
        madr_s  = V(4'd2,  6'b000000, 2'b00, 2'b10, 2'b01, 3'b001, 3'b000, 1'b0, 2'b00);
        mrd     = V(4'd3,  6'b011000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 2'b00);
        mwb     = V(4'd4,  6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 2'b00);
        mwr     = V(4'd5,  6'b010100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b0, 2'b00);
        br_t    = V(4'd9,  6'b100000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 1'b0, 2'b00);
        br_nt   = V(4'd9,  6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b001, 1'b0, 2'b00);
        bltu    = V(4'd9,  6'b100000, 2'b00, 2'b10, 2'b00, 3'b000, 3'b110, 1'b0, 2'b00);
        jalr    = V(4'd11, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 1'b0, 2'b00);
        jal     = V(4'd10, 6'b100000, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 1'b0, 2'b00);
        trap01  = V(4'd15, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 2'b01);
        trap10  = V(4'd15, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 2'b10);

        RST = 1'b1;
        bus.Instr = 32'h0;
        bus.MemReady = 1'b0;
        bus.Zero = 1'b0;
        do_reset("reset");

        bus.Instr = 32'h00500093;
        push("addi fetch", fr, 1'b1, 1'b0);
        push("addi decode", dec, 1'b1, 1'b0);
        push("addi execi", exi_add, 1'b1, 1'b0);
        push("addi aluwb", awb, 1'b1, 1'b0);
        drain();

        bus.Instr = 32'h402081B3;
        push("sub fetch", fr, 1'b1, 1'b0);
        push("sub decode", dec, 1'b1, 1'b0);
        push("sub execr", exr_sub, 1'b1, 1'b0);
        push("sub aluwb", awb, 1'b1, 1'b0);
        drain();

        bus.Instr = 32'h0000A103;
        push("lw fetch", fr, 1'b1, 1'b0);
        push("lw decode", dec, 1'b1, 1'b0);
        push("lw memadr", madr_l, 1'b1, 1'b0);
        push("lw memread w1", mrd, 1'b0, 1'b0);
        push("lw memread w2", mrd, 1'b0, 1'b0);
        push("lw memread rdy", mrd, 1'b1, 1'b0);
        push("lw memwb", mwb, 1'b1, 1'b0);
        drain();

        bus.Instr = 32'h0020A023;
        push("sw fetch", fr, 1'b1, 1'b0);
        push("sw decode", dec, 1'b1, 1'b0);
        push("sw memadr", madr_s, 1'b1, 1'b0);
        push("sw memwrite w1", mwr, 1'b0, 1'b0);
        push("sw memwrite rdy", mwr, 1'b1, 1'b0);
        drain();

        bus.Instr = 32'h00208463;
        push("beq z1 fetch", fr, 1'b1, 1'b1);
        push("beq z1 decode", dec, 1'b1, 1'b1);
        push("beq z1 branch", br_t, 1'b1, 1'b1);
        push("beq z0 fetch", fr, 1'b1, 1'b0);
        push("beq z0 decode", dec, 1'b1, 1'b0);
        push("beq z0 branch", br_nt, 1'b1, 1'b0);
        drain();

        bus.Instr = 32'h0020E463;
        push("bltu fetch", fr, 1'b1, 1'b0);
        push("bltu decode", dec, 1'b1, 1'b0);
        push("bltu branch", bltu, 1'b1, 1'b0);
        drain();

        bus.Instr = 32'h000080E7;
        push("jalr fetch", fr, 1'b1, 1'b0);
        push("jalr decode", dec, 1'b1, 1'b0);
        push("jalr jalr", jalr, 1'b1, 1'b0);
        push("jalr jal", jal, 1'b1, 1'b0);
        push("jalr aluwb", awb, 1'b1, 1'b0);
        drain();

        bus.Instr = 32'h0000A103;
        push("lw2 fetch", fr, 1'b1, 1'b0);
        push("lw2 decode", dec, 1'b1, 1'b0);
        push("lw2 memadr", madr_l, 1'b1, 1'b0);
        push("lw2 memread", mrd, 1'b0, 1'b0);
        drain();
        do_reset("rst mid read");

        bus.Instr = 32'h0000007F;
        push("illegal fetch", fr, 1'b1, 1'b0);
        push("illegal decode", dec, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) push($sformatf("illegal trap %0d", i), trap01, 1'b1, 1'b0);
        drain();
        do_reset("rst after illegal");

        bus.Instr = 32'h00109093;
        push("slli fetch", fr, 1'b1, 1'b0);
        push("slli decode", dec, 1'b1, 1'b0);
        push("slli trap", trap01, 1'b1, 1'b0);
        drain();
        do_reset("rst after slli");

        bus.Instr = 32'h0020A463;
        push("bf3_010 fetch", fr, 1'b1, 1'b0);
        push("bf3_010 decode", dec, 1'b1, 1'b0);
        push("bf3_010 trap", trap01, 1'b1, 1'b0);
        drain();
        do_reset("rst after bf3_010");

        bus.Instr = 32'h00500093;
        for (int i = 0; i < 4; i++) push($sformatf("timeout wait %0d", i), fw, 1'b0, 1'b0);
        push("timeout trap", trap10, 1'b0, 1'b0);
        push("timeout trap hold", trap10, 1'b1, 1'b0);
        drain();
        do_reset("rst after timeout");

        for (int i = 0; i < 3; i++) push($sformatf("late rdy wait %0d", i), fw, 1'b0, 1'b0);
        push("late rdy fetch", fr, 1'b1, 1'b0);
        push("late rdy decode", dec, 1'b1, 1'b0);
        push("late rdy execi", exi_add, 1'b1, 1'b0);
        push("late rdy aluwb", awb, 1'b1, 1'b0);
        drain();

        bus.Instr = 32'h123450B7;
        push("lui fetch", fr, 1'b1, 1'b0);
        push("lui decode", dec, 1'b1, 1'b0);
`ifdef MC_UTYPE_EN
        push("lui utype", utype, 1'b1, 1'b0);
        push("lui aluwb", awb, 1'b1, 1'b0);
`else
        push("lui trap", trap01, 1'b1, 1'b0);
`endif
        drain();
        do_reset("rst after lui");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
